// File: rtl/sd_cmd_serial_host.sv
// sd_cmd_serial_host: serialises a 40-bit SD command with CRC7 onto CMD and captures the card response.
module sd_cmd_serial_host #(
    parameter int INIT_CYCLES = 74,
    parameter int NCR_TIMEOUT = 64
) (
    input  logic        CLK_PAD_IO,
    input  logic        RST_PAD_I,
    input  logic [15:0] settings_i,
    input  logic [39:0] cmd_i,
    input  logic        req_i,
    input  logic        ack_i,
    input  logic        go_idle_i,
    output logic        req_o,
    output logic        ack_o,
    output logic [39:0] cmd_o,
    output logic [7:0]  status_o,
    input  logic        cmd_dat_i,
    output logic        cmd_out_o,
    output logic        cmd_oe_o
);
    typedef enum logic [2:0] {INIT, IDLE, WRITE, DELAY, READ_WAIT, READ, FINISH, WAIT_ACK_LOW} state_t;
    localparam logic [7:0] L_INIT = 8'(INIT_CYCLES);
    localparam logic [7:0] L_NCR = 8'(NCR_TIMEOUT - 1);
    state_t      r_state;
    logic [1:0]  r_req_sync, r_ack_sync;
    logic        r_req_d;
    logic [39:0] r_shift;
    logic [6:0]  r_crc;
    logic [7:0]  r_cnt;
    logic [2:0]  r_dly;
    logic [6:0]  r_size;
    logic        r_timeout, r_crc_ok;
    logic        w_req_s, w_ack_s, w_long;
    logic [7:0]  w_bit, w_last, w_cnt_inc;
    logic        w_unused;
    assign w_req_s   = r_req_sync[1];
    assign w_ack_s   = r_ack_sync[1];
    assign w_long    = r_size != 7'd40;
    assign w_bit     = r_cnt + 8'd1;
    assign w_last    = w_long ? 8'd136 : 8'd48;
    assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
    assign w_unused  = &{1'b0, settings_i[15:11], settings_i[7]};
    function automatic logic [6:0] crc_next(input logic [6:0] c, input logic b);
        return {c[5:0], 1'b0} ^ ((b ^ c[6]) ? 7'h09 : 7'h00);
    endfunction
    always_ff @(posedge CLK_PAD_IO) begin
        if (RST_PAD_I) begin
            r_state    <= INIT;
            r_req_sync <= '0;
            r_ack_sync <= '0;
            r_req_d    <= 1'b0;
            r_shift    <= '0;
            r_crc      <= '0;
            r_cnt      <= '0;
            r_dly      <= '0;
            r_size     <= '0;
            r_timeout  <= 1'b0;
            r_crc_ok   <= 1'b0;
            req_o      <= 1'b0;
            ack_o      <= 1'b0;
            cmd_o      <= '0;
            status_o   <= '0;
            cmd_out_o  <= 1'b1;
            cmd_oe_o   <= 1'b0;
        end else begin
            r_req_sync <= {r_req_sync[0], req_i};
            r_ack_sync <= {r_ack_sync[0], ack_i};
            r_req_d    <= w_req_s;
            if (go_idle_i && r_state != INIT) begin
                r_state   <= IDLE;
                cmd_oe_o  <= 1'b0;
                cmd_out_o <= 1'b1;
                req_o     <= 1'b0;
                ack_o     <= 1'b1;
            end else begin
                case (r_state)
                    INIT: begin
                        r_cnt     <= w_cnt_inc;
                        cmd_out_o <= 1'b1;
                        cmd_oe_o  <= r_cnt != L_INIT;
                        if (r_cnt == L_INIT) begin
                            r_state <= IDLE;
                            ack_o   <= 1'b1;
                        end
                    end
                    IDLE: if (w_req_s && !r_req_d) begin
                        // Start bit goes out on the accept edge so the frame begins with oe.
                        r_dly     <= settings_i[10:8];
                        r_size    <= settings_i[6:0];
                        r_shift   <= {cmd_i[38:0], 1'b0};
                        r_crc     <= crc_next(7'd0, cmd_i[39]);
                        r_cnt     <= 8'd1;
                        r_timeout <= 1'b0;
                        r_crc_ok  <= 1'b1;
                        cmd_out_o <= cmd_i[39];
                        cmd_oe_o  <= 1'b1;
                        ack_o     <= 1'b0;
                        r_state   <= WRITE;
                    end
                    WRITE: begin
                        r_cnt <= w_cnt_inc;
                        if (r_cnt < 8'd40) begin
                            cmd_out_o <= r_shift[39];
                            r_shift   <= {r_shift[38:0], 1'b0};
                            r_crc     <= crc_next(r_crc, r_shift[39]);
                        end else if (r_cnt < 8'd47) begin
                            cmd_out_o <= r_crc[6];
                            r_crc     <= {r_crc[5:0], 1'b0};
                        end else begin
                            cmd_out_o <= 1'b1;
                            r_cnt     <= 8'd0;
                            r_state   <= DELAY;
                        end
                    end
                    DELAY: if (r_cnt < {5'd0, r_dly}) r_cnt <= w_cnt_inc;
                    else begin
                        cmd_oe_o <= 1'b0;
                        r_cnt    <= 8'd0;
                        r_crc    <= 7'd0;
                        r_state  <= (r_size == 7'd0) ? FINISH : READ_WAIT;
                    end
                    READ_WAIT: if (!cmd_dat_i) begin
                        cmd_o   <= {cmd_o[38:0], 1'b0};
                        r_crc   <= crc_next(r_crc, 1'b0);
                        r_cnt   <= 8'd1;
                        r_state <= READ;
                    end else if (r_cnt == L_NCR) begin
                        r_timeout <= 1'b1;
                        r_crc_ok  <= 1'b0;
                        r_state   <= FINISH;
                    end else r_cnt <= w_cnt_inc;
                    READ: begin
                        r_cnt <= w_cnt_inc;
                        if (w_bit <= 8'd40) begin
                            cmd_o <= {cmd_o[38:0], cmd_dat_i};
                            r_crc <= crc_next(r_crc, cmd_dat_i);
                        end else begin
                            r_crc <= {r_crc[5:0], 1'b0};
                            if (!w_long && w_bit <= 8'd47 && cmd_dat_i != r_crc[6]) r_crc_ok <= 1'b0;
                        end
                        if (w_bit == w_last) r_state <= FINISH;
                    end
                    FINISH: if (!req_o) begin
                        status_o <= {r_timeout, 1'b1, r_crc_ok, 5'b0};
                        req_o    <= 1'b1;
                    end else if (w_ack_s) begin
                        req_o   <= 1'b0;
                        r_state <= WAIT_ACK_LOW;
                    end
                    WAIT_ACK_LOW: if (!w_ack_s) begin
                        r_state <= IDLE;
                        ack_o   <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sd_cmd_serial_host.sv
// tb_sd_cmd_serial_host: directed bench with frame/response scoreboards and a simple card model on CMD.
module tb_sd_cmd_serial_host;
    logic        clk = 1'b0, rst = 1'b1;
    logic [15:0] settings = '0;
    logic [39:0] cmd = '0;
    logic        req = 1'b0, ack = 1'b0, go_idle = 1'b0, cmd_dat = 1'b1;
    logic        req_o, ack_o, cmd_out_o, cmd_oe_o;
    logic [39:0] cmd_o;
    logic [7:0]  status_o;
    int          n_pass = 0, n_fail = 0, n_total = 0;
    typedef struct {logic [39:0] cmd; logic [7:0] st; logic chk_cmd;} rsp_t;
    logic [47:0] q_frame[$];
    rsp_t        q_rsp[$];

    sd_cmd_serial_host dut (
        .CLK_PAD_IO(clk), .RST_PAD_I(rst), .settings_i(settings), .cmd_i(cmd),
        .req_i(req), .ack_i(ack), .go_idle_i(go_idle), .req_o(req_o), .ack_o(ack_o),
        .cmd_o(cmd_o), .status_o(status_o), .cmd_dat_i(cmd_dat),
        .cmd_out_o(cmd_out_o), .cmd_oe_o(cmd_oe_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c = 7'd0;
        for (int i = 39; i >= 0; i--) c = {c[5:0], 1'b0} ^ ((d[i] ^ c[6]) ? 7'h09 : 7'h00);
        return c;
    endfunction

    function automatic logic sig(input int w);
        return (w == 0) ? cmd_oe_o : (w == 1) ? req_o : ack_o;
    endfunction

    task automatic wait_sig(input string tag, input int w, input logic v, input int budget);
        int n = 0;
        while (sig(w) !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(sig(w)), 64'(v));
    endtask

    task automatic init_phase(input string tag);
        int  n = 0;
        logic bad = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cmd_dat = 1'b1;
        repeat (3) @(negedge clk);
        chk({tag, "_rst_vals"}, {req_o, ack_o, cmd_o, status_o, cmd_out_o, cmd_oe_o},
            {1'b0, 1'b0, 40'h0, 8'h0, 1'b1, 1'b0});
        rst = 1'b0;
        @(negedge clk);
        while (!ack_o && n < 200) begin
            if (!cmd_oe_o || !cmd_out_o || req_o) bad = 1'b1;
            n++;
            @(negedge clk);
        end
        chk({tag, "_init_len"}, n, 74);
        chk({tag, "_init_drive"}, bad, 0);
        repeat (5) @(negedge clk);
        chk({tag, "_idle"}, {ack_o, cmd_oe_o, req_o}, 3'b100);
    endtask

    task automatic launch(input logic [39:0] c, input logic [15:0] s, input bit hold);
        cmd = c;
        settings = s;
        req = 1'b1;
        @(negedge clk);
        if (!hold) req = 1'b0;
    endtask

    task automatic do_txn(input logic [39:0] c, input logic [15:0] s, input bit hold,
                          input logic [135:0] rsp, input int len, input int gap,
                          input logic [39:0] exp_cmd, input logic [7:0] exp_st, input logic chk_cmd,
                          output logic [47:0] frame);
        int   n = 0;
        rsp_t r;
        q_frame.push_back({c, crc7(c), 1'b1});
        launch(c, s, hold);
        wait_sig("oe_rise", 0, 1'b1, 10);
        frame = '0;
        for (int i = 0; i < 48; i++) begin
            frame = {frame[46:0], cmd_out_o};
            @(negedge clk);
        end
        chk("frame", frame, q_frame.pop_front());
        while (cmd_oe_o && n < 20) begin
            if (!cmd_out_o) n = 100;
            n++;
            @(negedge clk);
        end
        chk("delay_cycles", n, 64'(s[10:8]));
        q_rsp.push_back('{cmd: exp_cmd, st: exp_st, chk_cmd: chk_cmd});
        if (len > 0) begin
            repeat (gap) @(negedge clk);
            for (int i = 0; i < len; i++) begin
                cmd_dat = rsp[135-i];
                @(negedge clk);
            end
            cmd_dat = 1'b1;
        end
        wait_sig("req_rise", 1, 1'b1, 200);
        r = q_rsp.pop_front();
        if (r.chk_cmd) chk("cmd_o", cmd_o, r.cmd);
        chk("status", status_o, r.st);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("req_hold", {req_o, cmd_o, status_o}, {1'b1, cmd_o, r.st});
        end
        ack = 1'b1;
        wait_sig("req_fall", 1, 1'b0, 10);
        ack = 1'b0;
        wait_sig("ack_o_rise", 2, 1'b1, 10);
    endtask

    initial begin
        logic [47:0]  frame;
        logic [39:0]  prev;
        logic         seen;
        logic [135:0] r48 = {48'h08_0000_01AA_13, 88'h0};
        logic [135:0] r48_bad = {48'h08_0000_01AA_15, 88'h0};
        logic [135:0] r136 = 136'h3F_0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

        init_phase("reset");

        do_txn(40'h40_0000_0000, 16'h0700, 1'b0, '0, 0, 0, 40'h0, 8'h60, 1'b0, frame);
        chk("cmd0_frame", frame, 48'h40_0000_0000_95);

        do_txn(40'h48_0000_01AA, 16'h02A8, 1'b0, r48, 48, 5, 40'h08_0000_01AA, 8'h60, 1'b1, frame);
        chk("cmd8_frame", frame, 48'h48_0000_01AA_87);
        do_txn(40'h48_0000_01AA, 16'h00A8, 1'b0, r48_bad, 48, 2, 40'h08_0000_01AA, 8'h40, 1'b1, frame);

        do_txn(40'h77_0000_0000, 16'h00A8, 1'b0, '0, 0, 0, 40'h0, 8'hC0, 1'b0, frame);
        do_txn(40'h42_0000_0000, 16'h01FF, 1'b0, r136, 136, 3, 40'h3F_0123_4567, 8'h60, 1'b1, frame);

        // req held high across the whole exchange must not start a second frame
        do_txn(40'h4D_1234_5678, 16'h0100, 1'b1, '0, 0, 0, 40'h0, 8'h60, 1'b0, frame);
        seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            seen |= cmd_oe_o;
        end
        chk("no_relaunch", seen, 0);
        req = 1'b0;
        repeat (5) @(negedge clk);

        launch(40'h51_0000_0000, 16'h00A8, 1'b0);
        wait_sig("gi_oe_rise", 0, 1'b1, 10);
        repeat (10) @(negedge clk);
        prev = cmd_o;
        go_idle = 1'b1;
        @(negedge clk);
        go_idle = 1'b0;
        chk("go_idle_now", {cmd_oe_o, ack_o, req_o, cmd_o}, {1'b0, 1'b1, 1'b0, prev});
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            seen |= cmd_oe_o | req_o;
        end
        chk("go_idle_quiet", seen, 0);

        launch(40'h48_0000_01AA, 16'h00A8, 1'b0);
        wait_sig("rst_oe_rise", 0, 1'b1, 10);
        wait_sig("rst_oe_fall", 0, 1'b0, 80);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            cmd_dat = r48[135-i];
            @(negedge clk);
        end
        init_phase("mid_read_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
